uart_rx_ext: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 115200-8N1 receiver.
//  - Configurable data width, parity mode and stop-bit count.
//  - 3-sample majority vote around each bit centre.
//  - Parity and framing error flags, qualified by valid.
//  - Sits between the board RX pin and the byte consumer (command parser/FIFO).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 33 +++
 rtl/uart_rx_ext.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_ext.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the RX and TX sides.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_IDLE
    } state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-FF synchroniser, 3-sample history, falling-edge detect, majority vote.
// Latency: 2 cycles to the synced line; no backpressure (free-running sampler).
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic line,
    output logic fall,
    output logic vote
);

    logic       sync1;
    logic       sync2;
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 2'b11;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
        end
    end

    assign line = sync2;
    assign fall = hist[0] & ~sync2;
    // hist[1], hist[0], sync2 are three consecutive samples of the synced line
    assign vote = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with majority-vote sampling and parity/framing flags; UART_RX_BREAK_EN adds the brk pulse.
// Latency: outputs register one cycle after the last stop-bit decision; no backpressure, each valid pulse must be taken.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err
`ifdef UART_RX_BREAK_EN
    ,
    output logic                 brk
`endif
);

    localparam int CPB = cycles_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int MID = CPB / 2 - 1;
    localparam int CW  = $clog2(CPB);

    if (CPB < 8) begin : g_bad_cpb
        $error("uart_rx_ext: CLK_FREQ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_ext: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > int'(PAR_EVEN)) begin : g_bad_parity
        $error("uart_rx_ext: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_ext: STOP_BITS must be 1 or 2");
    end

    logic                 line;
    logic                 fall;
    logic                 vote;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 at_dec;

    uart_rx_sampler u_sampler (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .line (line),
        .fall (fall),
        .vote (vote)
    );

    // After the start bit the counter restarts at 0, so every later decision is CPB cycles apart
    assign at_dec = (cnt == CW'(CPB - 1));

`ifdef UART_RX_BREAK_EN
    logic any_one;
    logic is_break;

    always_ff @(posedge clk) begin
        if (rst || state == START) begin
            any_one <= 1'b0;
        end else if ((state == DATA || state == PAR || state == STOP) && at_dec) begin
            any_one <= any_one | vote;
        end
    end

    assign is_break = ~(any_one | vote);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            brk        <= 1'b0;
`endif
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            brk        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) state <= START;
                end
                START: begin
                    if (cnt == CW'(MID)) begin
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        par_bad  <= 1'b0;
                        stop_bad <= 1'b0;
                        state    <= vote ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    cnt <= at_dec ? '0 : cnt + 1'b1;
                    if (at_dec) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ vote;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != int'(PAR_NONE)) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    cnt <= at_dec ? '0 : cnt + 1'b1;
                    if (at_dec) begin
                        par_bad <= ((par_acc ^ vote) != (PARITY == int'(PAR_ODD)));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    cnt <= at_dec ? '0 : cnt + 1'b1;
                    if (at_dec) begin
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state <= vote ? IDLE : WAIT_IDLE;
`ifdef UART_RX_BREAK_EN
                            if (is_break) begin
                                brk <= 1'b1;
                            end else begin
`endif
                                valid      <= 1'b1;
                                data       <= shreg;
                                parity_err <= par_bad;
                                frame_err  <= stop_bad | ~vote;
`ifdef UART_RX_BREAK_EN
                            end
`endif
                        end else begin
                            stop_bad <= stop_bad | ~vote;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (line) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three configurations (8N1, 7E1, 8O2) on one clock, frames built from a bit-level line model.
module tb_uart_rx_ext;

    localparam int CPB = 12_000_000 / 115200;
    localparam int MID = CPB / 2 - 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic line = 1'b1;
    int   sel  = 0;
    int   cyc  = 0;
    int   t_start = 0;
    int   nvec = 0;
    int   nerr = 0;

    logic       rx_a, rx_b, rx_c;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [7:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
`ifdef UART_RX_BREAK_EN
    logic       brk_a, brk_b, brk_c;
`endif

    int         vcnt [3];
    int         bcnt [3];
    int         vcyc [3];
    logic [8:0] ldat [3];
    bit         lpe  [3];
    bit         lfe  [3];

    int          d_cnt, d_bcnt, lat;
    logic [8:0]  o_dat;
    bit          o_pe, o_fe;
    bit          e_brk, e_pe, e_fe;
    logic [8:0]  e_dat;
    logic [15:0] bits;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ext #(.CLK_FREQ(12_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a), .parity_err(pe_a), .frame_err(fe_a)
`ifdef UART_RX_BREAK_EN
        , .brk(brk_a)
`endif
    );

    uart_rx_ext #(.CLK_FREQ(12_000_000), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b), .parity_err(pe_b), .frame_err(fe_b)
`ifdef UART_RX_BREAK_EN
        , .brk(brk_b)
`endif
    );

    uart_rx_ext #(.CLK_FREQ(12_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .rx(rx_c), .data(data_c), .valid(valid_c), .parity_err(pe_c), .frame_err(fe_c)
`ifdef UART_RX_BREAK_EN
        , .brk(brk_c)
`endif
    );

    always @(negedge clk) begin
        if (valid_a) begin vcnt[0]++; ldat[0] = {1'b0, data_a}; lpe[0] = pe_a; lfe[0] = fe_a; vcyc[0] = cyc; end
        if (valid_b) begin vcnt[1]++; ldat[1] = {2'b0, data_b}; lpe[1] = pe_b; lfe[1] = fe_b; vcyc[1] = cyc; end
        if (valid_c) begin vcnt[2]++; ldat[2] = {1'b0, data_c}; lpe[2] = pe_c; lfe[2] = fe_c; vcyc[2] = cyc; end
`ifdef UART_RX_BREAK_EN
        if (brk_a) bcnt[0]++;
        if (brk_b) bcnt[1]++;
        if (brk_c) bcnt[2]++;
`endif
    end

    // Line image of one frame: start, data LSB first, optional parity, stop bits
    function automatic logic [15:0] build(input logic [8:0] d, input int nd, input int pm, input int ns,
                                          input bit flip, input bit last_low);
        logic [15:0] b;
        int          np;
        logic        p;
        b    = '1;
        b[0] = 1'b0;
        np   = (pm != 0) ? 1 : 0;
        for (int i = 0; i < nd; i++) b[1+i] = d[i];
        if (np == 1) begin
            p = 1'b0;
            for (int i = 0; i < nd; i++) p = p ^ d[i];
            if (pm == 1) p = ~p;
            b[1+nd] = p ^ flip;
        end
        if (last_low) b[nd+np+ns] = 1'b0;
        return b;
    endfunction

    function automatic void model(input logic [15:0] b, input int nd, input int pm, input int ns,
                                  output bit m_brk, output logic [8:0] m_dat, output bit m_pe, output bit m_fe);
        int np, w, ones;
        np    = (pm != 0) ? 1 : 0;
        m_dat = '0;
        m_fe  = 1'b0;
        w     = 0;
        for (int i = 0; i < nd; i++) m_dat[i] = b[1+i];
        for (int i = 1; i <= nd + np; i++) w += int'(b[i]);
        ones = w;
        for (int i = 0; i < ns; i++) begin
            ones += int'(b[1+nd+np+i]);
            if (b[1+nd+np+i] == 1'b0) m_fe = 1'b1;
        end
        m_pe = (np == 1) && (((w % 2) == 1) != (pm == 1));
`ifdef UART_RX_BREAK_EN
        m_brk = (ones == 0);
`else
        m_brk = 1'b0;
`endif
    endfunction

    task automatic drive_frame(input int s, input logic [15:0] b, input int nbits, input bit glitch, input int rst_bit);
        sel = s;
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) t_start = cyc;
                line = b[k] ^ (glitch && c == MID - 1);
                if (k == rst_bit && c == MID) begin
                    rst  = 1'b1;
                    line = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic run_frame(input int s, input logic [15:0] b, input int nbits, input bit glitch);
        int c0, b0;
        c0 = vcnt[s];
        b0 = bcnt[s];
        drive_frame(s, b, nbits, glitch, -1);
        repeat (4) @(negedge clk);
        d_cnt  = vcnt[s] - c0;
        d_bcnt = bcnt[s] - b0;
        o_dat  = ldat[s];
        o_pe   = lpe[s];
        o_fe   = lfe[s];
        lat    = vcyc[s] - t_start;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (valid_a !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", valid_a); end
        nvec++; if (data_a !== 8'h00) begin nerr++; $display("FAIL reset_data got %h want 00", data_a); end
        nvec++; if (pe_a !== 1'b0) begin nerr++; $display("FAIL reset_perr got %b want 0", pe_a); end
        nvec++; if (fe_a !== 1'b0) begin nerr++; $display("FAIL reset_ferr got %b want 0", fe_a); end
        nvec++; if (data_c !== 8'h00) begin nerr++; $display("FAIL reset_data_c got %h want 00", data_c); end
`ifdef UART_RX_BREAK_EN
        nvec++; if (brk_a !== 1'b0) begin nerr++; $display("FAIL reset_brk got %b want 0", brk_a); end
`endif
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        nvec++; if (vcnt[0] !== 0) begin nerr++; $display("FAIL idle_no_valid got %0d want 0", vcnt[0]); end
    endtask

    task automatic test_basic;
        bits = build(9'h0A5, 8, 0, 1, 1'b0, 1'b0);
        model(bits, 8, 0, 1, e_brk, e_dat, e_pe, e_fe);
        run_frame(0, bits, 10, 1'b0);
        nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL basic_cnt got %0d want 1", d_cnt); end
        nvec++; if (o_dat !== 9'h0A5) begin nerr++; $display("FAIL basic_data got %h want a5", o_dat); end
        nvec++; if (o_pe !== e_pe) begin nerr++; $display("FAIL basic_perr got %b want %b", o_pe, e_pe); end
        nvec++; if (o_fe !== e_fe) begin nerr++; $display("FAIL basic_ferr got %b want %b", o_fe, e_fe); end
        nvec++; if (lat !== (1 + 8 + 0 + 1 - 1) * CPB + MID + 1 + 2 + 1)
            begin nerr++; $display("FAIL basic_latency got %0d want %0d", lat, (1 + 8 + 0 + 1 - 1) * CPB + MID + 4); end
    endtask

    task automatic test_parity;
        for (int f = 0; f < 2; f++) begin
            bits = build(9'h041, 7, 2, 1, f[0], 1'b0);
            model(bits, 7, 2, 1, e_brk, e_dat, e_pe, e_fe);
            run_frame(1, bits, 10, 1'b0);
            nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL parity_cnt[%0d] got %0d want 1", f, d_cnt); end
            nvec++; if (o_dat !== 9'h041) begin nerr++; $display("FAIL parity_data[%0d] got %h want 41", f, o_dat); end
            nvec++; if (o_pe !== f[0]) begin nerr++; $display("FAIL parity_err[%0d] got %b want %b", f, o_pe, f[0]); end
            nvec++; if (o_pe !== e_pe) begin nerr++; $display("FAIL parity_model[%0d] got %b want %b", f, o_pe, e_pe); end
            nvec++; if (lat !== (1 + 7 + 1 + 1 - 1) * CPB + MID + 4)
                begin nerr++; $display("FAIL parity_latency[%0d] got %0d want %0d", f, lat, (1 + 7 + 1 + 1 - 1) * CPB + MID + 4); end
        end
    endtask

    task automatic test_stop2;
        int c1;
        bits = build(9'h096, 8, 1, 2, 1'b0, 1'b1);
        model(bits, 8, 1, 2, e_brk, e_dat, e_pe, e_fe);
        run_frame(2, bits, 12, 1'b0);
        nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL stop2_cnt got %0d want 1", d_cnt); end
        nvec++; if (o_fe !== 1'b1) begin nerr++; $display("FAIL stop2_ferr got %b want 1", o_fe); end
        nvec++; if (o_dat !== e_dat) begin nerr++; $display("FAIL stop2_data got %h want %h", o_dat, e_dat); end
        nvec++; if (o_pe !== e_pe) begin nerr++; $display("FAIL stop2_perr got %b want %b", o_pe, e_pe); end
        c1 = vcnt[2];
        repeat (3 * CPB) @(negedge clk);
        line = 1'b1;
        repeat (CPB) @(negedge clk);
        nvec++; if (vcnt[2] !== c1) begin nerr++; $display("FAIL stop2_quiet got %0d want %0d", vcnt[2], c1); end
        bits = build(9'h03B, 8, 1, 2, 1'b0, 1'b0);
        model(bits, 8, 1, 2, e_brk, e_dat, e_pe, e_fe);
        run_frame(2, bits, 12, 1'b0);
        nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL stop2_next_cnt got %0d want 1", d_cnt); end
        nvec++; if (o_dat !== 9'h03B) begin nerr++; $display("FAIL stop2_next_data got %h want 3b", o_dat); end
        nvec++; if (o_fe !== 1'b0 || o_pe !== 1'b0) begin nerr++; $display("FAIL stop2_next_flags got %b%b want 00", o_pe, o_fe); end
        nvec++; if (lat !== (1 + 8 + 1 + 2 - 1) * CPB + MID + 4)
            begin nerr++; $display("FAIL stop2_latency got %0d want %0d", lat, (1 + 8 + 1 + 2 - 1) * CPB + MID + 4); end
    endtask

    task automatic test_glitch;
        int c1;
        sel = 0;
        c1  = vcnt[0];
        @(negedge clk);
        line = 1'b0;
        repeat (40) @(negedge clk);
        line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        nvec++; if (vcnt[0] !== c1) begin nerr++; $display("FAIL glitch_no_valid got %0d want %0d", vcnt[0], c1); end
        bits = build(9'h03C, 8, 0, 1, 1'b0, 1'b0);
        run_frame(0, bits, 10, 1'b1);
        nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL vote_cnt got %0d want 1", d_cnt); end
        nvec++; if (o_dat !== 9'h03C) begin nerr++; $display("FAIL vote_data got %h want 3c", o_dat); end
        nvec++; if (o_fe !== 1'b0) begin nerr++; $display("FAIL vote_ferr got %b want 0", o_fe); end
    endtask

    task automatic test_rst_mid;
        int c1;
        c1   = vcnt[0];
        bits = build(9'h0C3, 8, 0, 1, 1'b0, 1'b0);
        drive_frame(0, bits, 10, 1'b0, 5);
        @(negedge clk);
        nvec++; if (data_a !== 8'h00) begin nerr++; $display("FAIL rst_mid_data got %h want 00", data_a); end
        nvec++; if (valid_a !== 1'b0 || pe_a !== 1'b0 || fe_a !== 1'b0)
            begin nerr++; $display("FAIL rst_mid_flags got %b%b%b want 000", valid_a, pe_a, fe_a); end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        nvec++; if (vcnt[0] !== c1) begin nerr++; $display("FAIL rst_mid_aborted got %0d want %0d", vcnt[0], c1); end
        bits = build(9'h05A, 8, 0, 1, 1'b0, 1'b0);
        run_frame(0, bits, 10, 1'b0);
        nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL rst_next_cnt got %0d want 1", d_cnt); end
        nvec++; if (o_dat !== 9'h05A) begin nerr++; $display("FAIL rst_next_data got %h want 5a", o_dat); end
    endtask

    task automatic test_break;
        int c1, b1;
        bits = 16'h0000;
        run_frame(0, bits, 12, 1'b0);
`ifdef UART_RX_BREAK_EN
        nvec++; if (d_bcnt !== 1) begin nerr++; $display("FAIL break_brk got %0d want 1", d_bcnt); end
        nvec++; if (d_cnt !== 0) begin nerr++; $display("FAIL break_no_valid got %0d want 0", d_cnt); end
        nvec++; if (data_a !== 8'h5A) begin nerr++; $display("FAIL break_data_hold got %h want 5a", data_a); end
`else
        nvec++; if (d_cnt !== 1) begin nerr++; $display("FAIL break_cnt got %0d want 1", d_cnt); end
        nvec++; if (o_dat !== 9'h000) begin nerr++; $display("FAIL break_data got %h want 00", o_dat); end
        nvec++; if (o_fe !== 1'b1) begin nerr++; $display("FAIL break_ferr got %b want 1", o_fe); end
`endif
        c1 = vcnt[0];
        b1 = bcnt[0];
        repeat (2 * CPB) @(negedge clk);
        line = 1'b1;
        repeat (CPB) @(negedge clk);
        nvec++; if (vcnt[0] !== c1 || bcnt[0] !== b1)
            begin nerr++; $display("FAIL break_quiet got %0d/%0d want %0d/%0d", vcnt[0], bcnt[0], c1, b1); end
        bits = build(9'h081, 8, 0, 1, 1'b0, 1'b0);
        run_frame(0, bits, 10, 1'b0);
        nvec++; if (d_cnt !== 1 || o_dat !== 9'h081)
            begin nerr++; $display("FAIL break_recover got %0d/%h want 1/81", d_cnt, o_dat); end
    endtask

    task automatic test_random;
        logic [8:0] d;
        bit         fl;
        for (int i = 0; i < 4; i++) begin
            d    = 9'($urandom_range(0, 255));
            bits = build(d, 8, 0, 1, 1'b0, 1'b0);
            model(bits, 8, 0, 1, e_brk, e_dat, e_pe, e_fe);
            run_frame(0, bits, 10, 1'b0);
            nvec++; if (d_cnt !== 1 || o_dat !== e_dat || o_pe !== e_pe || o_fe !== e_fe)
                begin nerr++; $display("FAIL rand_8n1[%0d] got %0d/%h/%b/%b want 1/%h/%b/%b", i, d_cnt, o_dat, o_pe, o_fe, e_dat, e_pe, e_fe); end
        end
        for (int i = 0; i < 4; i++) begin
            d    = 9'($urandom_range(0, 255));
            fl   = 1'($urandom_range(0, 1));
            bits = build(d, 8, 1, 2, fl, 1'b0);
            model(bits, 8, 1, 2, e_brk, e_dat, e_pe, e_fe);
            run_frame(2, bits, 12, 1'b0);
            nvec++; if (d_cnt !== 1 || o_dat !== e_dat || o_pe !== e_pe || o_fe !== e_fe)
                begin nerr++; $display("FAIL rand_8o2[%0d] got %0d/%h/%b/%b want 1/%h/%b/%b", i, d_cnt, o_dat, o_pe, o_fe, e_dat, e_pe, e_fe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_glitch();
        test_rst_mid();
        test_break();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
